// File: rtl/tts_pkg.sv
// Shared state encodings, default MISR taps and index-to-Gray mapping for the sweeper.
package tts_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [15:0] SIG_POLY_DEFAULT = 16'h8016;

    // Reflected binary Gray code of a sequence index (up to 16 bits).
    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_misr.sv
// Multiple-input signature register: shift left, feedback from tapped bits, XOR in response.
module sig_misr #(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    POLY = W'(16'h8016),
    parameter logic [W-1:0]    SEED = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    // Seed on reset or load; compress one response word when enabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[W-2:0], ^(q & POLY)} ^ din;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper: walks every input vector into a combinational block and
// compresses its responses into a MISR signature checked against a golden value.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int unsigned      N_IN     = 4,
    parameter int unsigned      N_OUT    = 8,
    parameter int unsigned      HOLD     = 1,
    parameter int unsigned      SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEFAULT),
    parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_gray,
    input  logic [SIG_W-1:0] golden,
    input  logic [N_OUT-1:0] resp,
    output logic [N_IN-1:0]  stim,
    output logic [N_IN-1:0]  vec_idx,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int unsigned     HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = '1;

    // Reject parameter sets that cannot work.
    if (N_OUT > SIG_W) begin : g_chk_nout
        $error("truth_table_sweeper: N_OUT must not exceed SIG_W");
    end
    if (HOLD < 1) begin : g_chk_hold
        $error("truth_table_sweeper: HOLD must be at least 1");
    end
    if (N_IN < 1) begin : g_chk_nin
        $error("truth_table_sweeper: N_IN must be at least 1");
    end

    logic [1:0]       state, state_nx;
    logic [N_IN-1:0]  vec_idx_nx;
    logic [HCW-1:0]   hold_cnt, hold_cnt_nx;
    logic             gray, gray_nx;
    logic             pass_nx;
    logic             misr_load;
    logic             misr_en;
    logic [SIG_W-1:0] sig_step;

    // Next-state, counters, MISR controls and final compare.
    always_comb begin
        state_nx    = state;
        vec_idx_nx  = vec_idx;
        hold_cnt_nx = hold_cnt;
        gray_nx     = gray;
        pass_nx     = pass;
        misr_load   = 1'b0;
        misr_en     = 1'b0;
        // Value the MISR takes on this edge if it compresses; used so pass lines up with done.
        sig_step    = {signature[SIG_W-2:0], ^(signature & SIG_POLY)} ^ SIG_W'(resp);
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nx    = ST_APPLY;
                    vec_idx_nx  = '0;
                    hold_cnt_nx = '0;
                    gray_nx     = mode_gray;
                    pass_nx     = 1'b0;
                    misr_load   = 1'b1;
                end
            end
            ST_APPLY: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                    pass_nx  = 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    misr_en     = 1'b1;
                    hold_cnt_nx = '0;
                    if (vec_idx == IDX_LAST) begin
                        state_nx = ST_DONE;
                        pass_nx  = (sig_step == golden);
                    end else begin
                        vec_idx_nx = vec_idx + N_IN'(1);
                    end
                end else begin
                    hold_cnt_nx = hold_cnt + HCW'(1);
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; stim/sample derive from next values so they never lag vec_idx.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            vec_idx  <= '0;
            hold_cnt <= '0;
            gray     <= 1'b0;
            pass     <= 1'b0;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sample   <= 1'b0;
        end else begin
            state    <= state_nx;
            vec_idx  <= vec_idx_nx;
            hold_cnt <= hold_cnt_nx;
            gray     <= gray_nx;
            pass     <= pass_nx;
            stim     <= gray_nx ? N_IN'(bin2gray(16'(vec_idx_nx))) : vec_idx_nx;
            busy     <= (state_nx == ST_APPLY);
            done     <= (state_nx == ST_DONE);
            sample   <= (state_nx == ST_APPLY) && (hold_cnt_nx == HOLD_LAST);
        end
    end

    sig_misr #(
        .W    (SIG_W),
        .POLY (SIG_POLY),
        .SEED (SIG_SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (misr_load),
        .en    (misr_en),
        .din   (SIG_W'(resp)),
        .q     (signature)
    );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a 4-input sweeper with HOLD=1 and a 2-input one with HOLD=3.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: N_IN=4, N_OUT=8, HOLD=1
    logic        start_a, abort_a, gray_a;
    logic [15:0] golden_a, sig_a;
    logic [7:0]  resp_a;
    logic [3:0]  stim_a, idx_a;
    logic        sample_a, busy_a, done_a, pass_a;

    // Instance B: N_IN=2, N_OUT=8, HOLD=3, responses tied low
    logic        start_b, abort_b, gray_b;
    logic [15:0] golden_b, sig_b;
    logic [7:0]  resp_b;
    logic [1:0]  stim_b, idx_b;
    logic        sample_b, busy_b, done_b, pass_b;

    // Combinational block under test for A: upper nibble stim^5, lower nibble stim.
    assign resp_a = {stim_a ^ 4'h5, stim_a};
    assign resp_b = 8'h00;

    truth_table_sweeper #(.N_IN(4), .N_OUT(8), .HOLD(1), .SIG_W(16)) dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .abort(abort_a), .mode_gray(gray_a),
        .golden(golden_a), .resp(resp_a), .stim(stim_a), .vec_idx(idx_a), .sample(sample_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
    );

    truth_table_sweeper #(.N_IN(2), .N_OUT(8), .HOLD(3), .SIG_W(16)) dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .abort(abort_b), .mode_gray(gray_b),
        .golden(golden_b), .resp(resp_b), .stim(stim_b), .vec_idx(idx_b), .sample(sample_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
    );

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
    } vec_t;

    vec_t tbl[16];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] resp_of(input logic [3:0] s);
        return {s ^ 4'h5, s};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
        return {s[14:0], ^(s & 16'h8016)} ^ {8'h00, r};
    endfunction

    function automatic logic [15:0] sweep_sig(input logic g);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < 16; i++) s = misr_step(s, resp_of(g ? tbl[i].gray : tbl[i].bin));
        return s;
    endfunction

    initial begin
        logic [3:0]  gl[16];
        logic [15:0] exp;

        gl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        for (int i = 0; i < 16; i++) begin
            tbl[i].bin  = 4'(i);
            tbl[i].gray = gl[i];
        end

        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; gray_a = 1'b0; golden_a = 16'h0;
        start_b = 1'b0; abort_b = 1'b0; gray_b = 1'b0; golden_b = 16'h0;
        tick();
        tick();
        chk("rst_stim", 32'(stim_a), 32'h0);
        chk("rst_idx", 32'(idx_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_sample", 32'(sample_a), 32'h0);
        chk("rst_done", 32'(done_a), 32'h0);
        chk("rst_pass", 32'(pass_a), 32'h0);
        chk("rst_sig", 32'(sig_a), 32'h0);
        chk("rst_busy_b", 32'(busy_b), 32'h0);
        rst_n = 1'b1;
        tick();

        // Binary sweep with the right golden; a stray start mid-sweep must be ignored.
        golden_a = sweep_sig(1'b0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        exp = 16'h0;
        for (int i = 0; i < 16; i++) begin
            chk("bin_idx", 32'(idx_a), 32'(i));
            chk("bin_stim", 32'(stim_a), 32'(tbl[i].bin));
            chk("bin_sample", 32'(sample_a), 32'h1);
            chk("bin_busy", 32'(busy_a), 32'h1);
            chk("bin_done", 32'(done_a), 32'h0);
            chk("bin_sig", 32'(sig_a), 32'(exp));
            exp = misr_step(exp, resp_of(tbl[i].bin));
            if (i == 3) start_a = 1'b1;
            if (i == 4) start_a = 1'b0;
            tick();
        end
        chk("bin_done_hi", 32'(done_a), 32'h1);
        chk("bin_busy_lo", 32'(busy_a), 32'h0);
        chk("bin_sample_lo", 32'(sample_a), 32'h0);
        chk("bin_pass", 32'(pass_a), 32'h1);
        chk("bin_sig_final", 32'(sig_a), 32'(exp));
        chk("bin_idx_hold", 32'(idx_a), 32'hF);
        tick();
        chk("bin_done_pulse", 32'(done_a), 32'h0);
        chk("bin_pass_hold", 32'(pass_a), 32'h1);
        chk("bin_sig_frozen", 32'(sig_a), 32'(exp));

        // Abort while vec_idx=5 is being sampled: that response must not be compressed.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("abt_pass_clr", 32'(pass_a), 32'h0);
        chk("abt_sig_seed", 32'(sig_a), 32'h0);
        exp = 16'h0;
        for (int i = 0; i < 5; i++) begin
            exp = misr_step(exp, resp_of(tbl[i].bin));
            tick();
        end
        chk("abt_idx5", 32'(idx_a), 32'h5);
        chk("abt_sample", 32'(sample_a), 32'h1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abt_busy", 32'(busy_a), 32'h0);
        chk("abt_sample_lo", 32'(sample_a), 32'h0);
        chk("abt_sig", 32'(sig_a), 32'(exp));
        for (int i = 0; i < 3; i++) begin
            chk("abt_no_done", 32'(done_a), 32'h0);
            chk("abt_pass", 32'(pass_a), 32'h0);
            tick();
        end

        // abort and start together in IDLE: abort wins.
        abort_a = 1'b1;
        start_a = 1'b1;
        tick();
        abort_a = 1'b0;
        start_a = 1'b0;
        chk("abst_busy", 32'(busy_a), 32'h0);
        chk("abst_sig", 32'(sig_a), 32'(exp));
        tick();
        chk("abst_busy2", 32'(busy_a), 32'h0);

        // Gray sweep, mode latched at start, golden off by bit 0 -> pass=0.
        golden_a = sweep_sig(1'b1) ^ 16'h0001;
        gray_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        gray_a = 1'b0;
        exp = 16'h0;
        for (int i = 0; i < 16; i++) begin
            chk("gry_idx", 32'(idx_a), 32'(i));
            chk("gry_stim", 32'(stim_a), 32'(tbl[i].gray));
            chk("gry_sig", 32'(sig_a), 32'(exp));
            exp = misr_step(exp, resp_of(tbl[i].gray));
            tick();
        end
        chk("gry_done", 32'(done_a), 32'h1);
        chk("gry_pass_bad", 32'(pass_a), 32'h0);
        chk("gry_sig_final", 32'(sig_a), 32'(exp));
        tick();

        // Reset mid-sweep with start held high; start re-accepted once reset releases.
        start_a = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("mrs_busy_pre", 32'(busy_a), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("mrs_stim", 32'(stim_a), 32'h0);
        chk("mrs_idx", 32'(idx_a), 32'h0);
        chk("mrs_busy", 32'(busy_a), 32'h0);
        chk("mrs_sample", 32'(sample_a), 32'h0);
        chk("mrs_done", 32'(done_a), 32'h0);
        chk("mrs_pass", 32'(pass_a), 32'h0);
        chk("mrs_sig", 32'(sig_a), 32'h0);
        tick();
        chk("mrs_busy2", 32'(busy_a), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mrs_restart_busy", 32'(busy_a), 32'h1);
        chk("mrs_restart_idx", 32'(idx_a), 32'h0);
        chk("mrs_restart_sig", 32'(sig_a), 32'h0);
        tick();
        chk("mrs_idx1", 32'(idx_a), 32'h1);
        tick();
        chk("mrs_idx2", 32'(idx_a), 32'h2);
        start_a = 1'b0;
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("mrs_abort_busy", 32'(busy_a), 32'h0);

        // HOLD=3 on instance B: sample on every third cycle, zero responses keep signature 0.
        golden_b = 16'h0000;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int v = 0; v < 4; v++) begin
            for (int h = 0; h < 3; h++) begin
                chk("hld_idx", 32'(idx_b), 32'(v));
                chk("hld_stim", 32'(stim_b), 32'(v));
                chk("hld_sample", 32'(sample_b), (h == 2) ? 32'h1 : 32'h0);
                chk("hld_busy", 32'(busy_b), 32'h1);
                chk("hld_sig", 32'(sig_b), 32'h0);
                tick();
            end
        end
        chk("hld_done", 32'(done_b), 32'h1);
        chk("hld_pass", 32'(pass_b), 32'h1);
        chk("hld_sig_final", 32'(sig_b), 32'h0);
        tick();
        chk("hld_done_pulse", 32'(done_b), 32'h0);
        chk("hld_busy_lo", 32'(busy_b), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
